// File: rtl/act_interp_pipe.sv
// act_interp_pipe
//   Three-stage, multi-lane linear interpolator for the piecewise-linear
//   activation units. Per lane it computes
//     base + ((next_data - base) * remaining [+ 2^(FRAC_W-1)]) >>> FRAC_W
//   with a full-precision difference, so the result never wraps.
//   All lanes share one valid/ready handshake. The whole pipe stalls when
//   the output is held by the consumer.
//
// Parameters
//   DATA_W  signed width of base / next_data / result
//   FRAC_W  unsigned width of remaining (>= 1)
//   LANES   number of independent lanes
//   ROUND   0 = floor, 1 = round-half-up
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in_valid/in_ready   input handshake
//   base, next_data     LANES x DATA_W signed samples, lane i at [i*DATA_W +: DATA_W]
//   remaining           LANES x FRAC_W unsigned fraction
//   out_valid/out_ready output handshake
//   interpolated_value  LANES x DATA_W signed results
module act_interp_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned LANES  = 1,
    parameter int unsigned ROUND  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   base,
    input  logic [LANES*DATA_W-1:0]   next_data,
    input  logic [LANES*FRAC_W-1:0]   remaining,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   interpolated_value
);

    // Product width: (DATA_W+1)-bit difference times (FRAC_W+1)-bit fraction.
    localparam int unsigned PW = DATA_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] RND = (ROUND != 0) ? PW'(1 << (FRAC_W - 1)) : PW'(0);

    logic adv;

    logic v1_q, v2_q, v3_q;

    logic signed [DATA_W-1:0] b1_d   [LANES];
    logic signed [DATA_W-1:0] n1_d   [LANES];
    logic signed [DATA_W:0]   d1_d   [LANES];
    logic signed [FRAC_W:0]   r1_d   [LANES];
    logic signed [PW-1:0]     p2_d   [LANES];
    logic signed [DATA_W+1:0] sum3_d [LANES];
    logic signed [DATA_W-1:0] y3_d   [LANES];

    logic signed [DATA_W:0]   d1_q [LANES];
    logic signed [DATA_W-1:0] b1_q [LANES];
    logic signed [FRAC_W:0]   r1_q [LANES];
    logic signed [PW-1:0]     p2_q [LANES];
    logic signed [DATA_W-1:0] b2_q [LANES];
    logic signed [DATA_W-1:0] y3_q [LANES];

    always_comb begin
        adv = out_ready | ~v3_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            b1_d[i] = $signed(base[i*DATA_W +: DATA_W]);
            n1_d[i] = $signed(next_data[i*DATA_W +: DATA_W]);
            // One extra bit so next - base cannot wrap.
            d1_d[i] = $signed({n1_d[i][DATA_W-1], n1_d[i]}) - $signed({b1_d[i][DATA_W-1], b1_d[i]});
            r1_d[i] = $signed({1'b0, remaining[i*FRAC_W +: FRAC_W]});
            p2_d[i] = $signed({{(FRAC_W+1){d1_q[i][DATA_W]}}, d1_q[i]})
                    * $signed({{(DATA_W+1){r1_q[i][FRAC_W]}}, r1_q[i]})
                    + RND;
            // Upper PW-FRAC_W bits of p are exactly p >>> FRAC_W.
            sum3_d[i] = $signed({{2{b2_q[i][DATA_W-1]}}, b2_q[i]})
                      + $signed(p2_q[i][PW-1:FRAC_W]);
            // Result is bounded by base and next_data, so truncation is lossless.
            y3_d[i] = DATA_W'(sum3_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                d1_q[i] <= '0;
                b1_q[i] <= '0;
                r1_q[i] <= '0;
                p2_q[i] <= '0;
                b2_q[i] <= '0;
                y3_q[i] <= '0;
            end
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            for (int unsigned i = 0; i < LANES; i++) begin
                d1_q[i] <= d1_d[i];
                b1_q[i] <= b1_d[i];
                r1_q[i] <= r1_d[i];
                p2_q[i] <= p2_d[i];
                b2_q[i] <= b1_q[i];
                y3_q[i] <= y3_d[i];
            end
        end
    end

    always_comb begin
        in_ready           = adv;
        out_valid          = v3_q;
        interpolated_value = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            interpolated_value[i*DATA_W +: DATA_W] = y3_q[i];
        end
    end

endmodule

// File: tb/tb_act_interp_pipe.sv
// tb_act_interp_pipe
//   Directed bench for act_interp_pipe. Two instances share clock, reset
//   and handshake: u_m (4 lanes, floor) and u_r (1 lane, round-half-up).
module tb_act_interp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_m, out_valid_m;
    logic [31:0] base_m, next_m, y_m;
    logic [15:0] rem_m;

    logic        in_ready_r, out_valid_r;
    logic [7:0]  base_r, next_r, y_r;
    logic [3:0]  rem_r;

    int n_checks;
    int n_err;

    always #5 clk = ~clk;

    act_interp_pipe #(.DATA_W(8), .FRAC_W(4), .LANES(4), .ROUND(0)) u_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .base(base_m), .next_data(next_m), .remaining(rem_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .interpolated_value(y_m)
    );

    act_interp_pipe #(.DATA_W(8), .FRAC_W(4), .LANES(1), .ROUND(1)) u_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .base(base_r), .next_data(next_r), .remaining(rem_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .interpolated_value(y_r)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d (0x%h) expected=%0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] p8(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] v;
        v = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        return v;
    endfunction

    function automatic logic [15:0] p4(input int a0, input int a1, input int a2, input int a3);
        logic [15:0] v;
        v = {a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
        return v;
    endfunction

    // Scalar reference: floor division via arithmetic shift on a 32-bit int.
    function automatic int model(input int b, input int n, input int r, input int rnd);
        int p;
        p = (n - b) * r + ((rnd != 0) ? 8 : 0);
        return b + (p >>> 4);
    endfunction

    task automatic set_in(input logic [31:0] bm, input logic [31:0] nm, input logic [15:0] rm,
                          input int br, input int nr, input int rr);
        logic [31:0] tb_b, tb_n, tb_r;
        tb_b = br; tb_n = nr; tb_r = rr;
        base_m = bm;
        next_m = nm;
        rem_m  = rm;
        base_r = tb_b[7:0];
        next_r = tb_n[7:0];
        rem_r  = tb_r[3:0];
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sb[10], sn[10], sr[10], em[10], er[10];
        int sent, recv, n_stall;
        logic held, acc;
        logic [31:0] held_m;
        logic [7:0]  held_r;

        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in('0, '0, '0, 0, 0, 0);

        // Reset state
        tick;
        tick;
        chk("rst_out_valid", out_valid_m, 1'b0);
        chk("rst_in_ready", in_ready_m, 1'b1);
        chk("rst_value_m", y_m, 32'h0);
        chk("rst_value_r", y_r, 8'h0);
        rst = 1'b0;

        // Beat A: latency and basic values
        set_in(p8(16, 16, 16, -100), p8(48, 48, 48, 100), p4(8, 0, 15, 8), 0, -1, 8);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("lat_a_c1", out_valid_m, 1'b0);
        tick;
        chk("lat_a_c2", out_valid_m, 1'b0);
        tick;
        chk("lat_a_c3", out_valid_m, 1'b1);
        chk("basic_lane0", $signed(y_m[7:0]), 32);
        chk("a_lanes", y_m, p8(32, 16, 46, 0));
        chk("round_neg_half", $signed(y_r), 0);

        // Beats B, C, D back to back
        set_in(p8(127, 127, 0, 0), p8(-128, -128, -1, 1), p4(15, 1, 8, 8), 0, 1, 8);
        in_valid = 1'b1;
        tick;
        set_in(p8(-128, 5, -50, 100), p8(127, 5, -10, -20), p4(15, 7, 4, 9), 127, -128, 15);
        tick;
        set_in(p8(-128, 1, 10, -1), p8(127, 2, -10, 0), p4(0, 15, 8, 15), 127, -128, 1);
        tick;
        in_valid = 1'b0;
        chk("b_valid", out_valid_m, 1'b1);
        chk("b_lanes", y_m, p8(-113, 111, -1, 0));
        chk("round_pos_half", $signed(y_r), 1);
        tick;
        chk("c_valid", out_valid_m, 1'b1);
        chk("c_lanes", y_m, p8(111, 5, -40, 32));
        chk("round_nowrap_15", $signed(y_r), -112);
        tick;
        chk("d_valid", out_valid_m, 1'b1);
        chk("d_lanes", y_m, p8(-128, 1, 0, -1));
        chk("round_nowrap_1", $signed(y_r), 111);
        tick;
        chk("drain_valid", out_valid_m, 1'b0);

        // Backpressure stream
        for (int k = 0; k < 10; k++) begin
            sb[k] = -120 + 25 * k;
            sn[k] = 100 - 23 * k;
            sr[k] = k;
            em[k] = model(sb[k], sn[k], sr[k], 0);
            er[k] = model(sb[k], sn[k], sr[k], 1);
        end
        sent    = 0;
        recv    = 0;
        n_stall = 0;
        held    = 1'b0;
        held_m  = '0;
        held_r  = '0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 10) begin
                in_valid = (cyc < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                set_in(p8(sb[sent], 0, 0, 0), p8(sn[sent], 0, 0, 0), p4(sr[sent], 0, 0, 0),
                       sb[sent], sn[sent], sr[sent]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("stall_hold_valid", out_valid_m, 1'b1);
                chk("stall_hold_data_m", y_m, held_m);
                chk("stall_hold_data_r", y_r, held_r);
            end
            if (!out_ready && out_valid_m) begin
                chk("stall_in_ready", in_ready_m, 1'b0);
                n_stall++;
            end
            if (out_valid_m && out_ready) begin
                chk("stream_m", y_m, p8(em[recv], 0, 0, 0));
                chk("stream_r", $signed(y_r), er[recv]);
                recv++;
            end
            held   = out_valid_m && !out_ready;
            held_m = y_m;
            held_r = y_r;
            acc    = in_valid && in_ready_m;
            tick;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", recv, 10);
        chk("stall_cycles", n_stall, 5);
        for (int k = 0; k < 3; k++) begin
            chk("stream_no_dup", out_valid_m, 1'b0);
            tick;
        end

        // Reset with three beats in flight
        set_in(p8(16, 16, 16, -100), p8(48, 48, 48, 100), p4(8, 0, 15, 8), 0, -1, 8);
        in_valid = 1'b1;
        tick;
        tick;
        tick;
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid_m, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid_m, 1'b0);
        chk("mid_rst_value", y_m, 32'h0);
        chk("mid_rst_in_ready", in_ready_m, 1'b1);
        chk("mid_rst_value_r", y_r, 8'h0);

        set_in(p8(-128, 5, -50, 100), p8(127, 5, -10, -20), p4(15, 7, 4, 9), 127, -128, 15);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("post_rst_c1", out_valid_m, 1'b0);
        tick;
        chk("post_rst_c2", out_valid_m, 1'b0);
        tick;
        chk("post_rst_c3", out_valid_m, 1'b1);
        chk("post_rst_lanes", y_m, p8(111, 5, -40, 32));
        chk("post_rst_r", $signed(y_r), -112);
        tick;
        chk("post_rst_drain", out_valid_m, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/act_interp_pipe.md
# act_interp_pipe

Pipelined, multi-lane linear interpolator for the piecewise-linear activation units (tanh/sigmoid) in the LSTM datapath. It sits behind the activation LUT read stage. Each lane computes `base + (next_data - base) * remaining / 2^FRAC_W`. The difference is computed at full precision, so it never wraps, and rounding is selectable. A valid/ready handshake lets the block stall under downstream backpressure.

## Interface
- `DATA_W`, 8: signed width of `base`, `next_data` and the result.
- `FRAC_W`, 4: unsigned width of `remaining` (interpolation fraction). Must be ≥ 1.
- `LANES`, 1: number of independent lanes that share one handshake.
- `ROUND`, 0: 0 = floor (arithmetic shift); 1 = round-half-up (add 2^(FRAC_W-1) before the shift).

Ports:
- `clk`  in  1  clock. All logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `base`  in  LANES*DATA_W  signed LUT sample at the segment start. Lane i is at bits [i*DATA_W +: DATA_W].
- `next_data`  in  LANES*DATA_W  signed LUT sample at the segment end.
- `remaining`  in  LANES*FRAC_W  unsigned fraction, 0 … 2^FRAC_W−1.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `interpolated_value`  out  LANES*DATA_W  signed result per lane.

## Operation
- Lanes are identical and fully independent in arithmetic. They share valid/ready.
- Stage 1 (S1) registers, per lane:
  - `d = next_data − base`, sign-extended to DATA_W+1 bits.
  - `base`.
  - `remaining`, zero-extended to FRAC_W+1 bits (signed).
- Stage 2 (S2) registers:
  - `p = d * remaining`, signed, DATA_W+FRAC_W+2 bits.
  - `p` plus the rounding constant when ROUND=1.
  - `base`.
- Stage 3 (S3) registers `base + (p >>> FRAC_W)`, computed in DATA_W+2 bits.
  - The result is truncated to DATA_W bits.
  - The result always lies within [min(base,next_data), max(base,next_data)], so truncation is lossless. No saturation logic is needed.
- `remaining` = 0 gives exactly `base`.
- The result never equals `next_data` unless `base` = `next_data`, or rounding reaches it.
- Each stage has a valid bit: `v1`, `v2`, `v3`. `out_valid = v3`.
- Global advance: `adv = out_ready | ~v3`.
- `in_ready = adv`, combinational from `out_ready` and `v3`.
- When `adv` = 1, all stages shift: `v1 <= in_valid`, `v2 <= v1`, `v3 <= v2`, and data registers follow.
- When `adv` = 0, all stage registers hold.
- Bubbles are not collapsed.
- A beat is accepted when `in_valid & in_ready`. It is delivered when `out_valid & out_ready`.

## Timing
- Latency: 3 cycles from acceptance to `out_valid` with no backpressure. Throughput is 1 beat/cycle.
- Reset:
  - `v1`, `v2`, `v3` = 0, so `out_valid` = 0 and `in_ready` = 1 in the cycle after reset.
  - `interpolated_value` = 0.
  - Internal data registers cleared.
- Reset mid-operation discards all in-flight beats. No partial outputs.
- While `out_valid` = 1 and `out_ready` = 0, `interpolated_value` and `out_valid` stay stable.
- `in_ready` = 1 and `out_ready` = 1 together: simultaneous accept and deliver in the same cycle, with no loss.
- Input data is sampled only on an accepted beat. Inputs are don't-care otherwise.
- `in_valid` may drop at any time without penalty.

## Test plan
- Basic (DATA_W=8, FRAC_W=4, ROUND=0):
  - base=16, next=48, rem=8 → 32, out_valid exactly 3 cycles after acceptance.
  - rem=0 → 16.
  - rem=15 → 46.
- No-wrap: base=−100, next=100, rem=8 → 0.
  - base=127, next=−128, rem=15 → −112.
  - base=127, next=−128, rem=1 → 111.
- Rounding, base=0, next=−1, rem=8:
  - ROUND=0 → −1.
  - ROUND=1 → 0.
  - base=0, next=1, rem=8 with ROUND=1 → 1.
- Backpressure:
  - Stream 10 beats with random `in_valid`; hold `out_ready`=0 for 5 cycles mid-stream.
  - Outputs must be in order and none lost or duplicated.
  - Outputs must be stable while stalled.
  - `in_ready` must fall in the same cycle as the stall.
- Multi-lane (LANES=4): lanes given distinct base/next/rem → each lane matches its scalar reference model, with no cross-lane leakage.
- Reset mid-stream:
  - Assert `rst` for 1 cycle with 3 beats in flight.
  - The next cycle shows `out_valid`=0, `interpolated_value`=0, `in_ready`=1.
  - A new beat after reset arrives 3 cycles later with the correct value.
